// File: rtl/ntt_pkg.sv
// ntt_pkg: shared types and constants for the NTT sequencer.
package ntt_pkg;
  typedef enum logic [1:0] {IDLE, RUN, LAYER_END, DONE} state_t;
  localparam int Q_DILITHIUM = 8380417;
  localparam int Q_KYBER = 3329;
  localparam int LAYERS_DILITHIUM = 8;
  localparam int LAYERS_KYBER = 7;
  localparam int N = 256;
  localparam int ADDR_W = 8;
  // Smallest stride exponent: the innermost layer of the transform.
  function automatic logic [2:0] min_stride(input logic red);
    return red ? 3'(8 - LAYERS_KYBER) : 3'(8 - LAYERS_DILITHIUM);
  endfunction
endpackage

// File: rtl/ntt_ctrl_if.sv
// ntt_ctrl_if: start/busy/done handshake plus RAM, twiddle and butterfly control.
interface ntt_ctrl_if;
  import ntt_pkg::*;
  logic start_i;
  logic inverse_i;
  logic sel_red_i;
  logic busy_o;
  logic done_o;
  logic rd_en_o;
  logic [ADDR_W-1:0] rd_addr_a_o;
  logic [ADDR_W-1:0] rd_addr_b_o;
  logic wr_en_o;
  logic [ADDR_W-1:0] wr_addr_a_o;
  logic [ADDR_W-1:0] wr_addr_b_o;
  logic [ADDR_W-1:0] tw_addr_o;
  logic sel_butterfly_o;
  logic sel_red_o;
  modport master (
    output start_i, inverse_i, sel_red_i,
    input busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, wr_en_o,
    wr_addr_a_o, wr_addr_b_o, tw_addr_o, sel_butterfly_o, sel_red_o
  );
  modport slave (
    input start_i, inverse_i, sel_red_i,
    output busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, wr_en_o,
    wr_addr_a_o, wr_addr_b_o, tw_addr_o, sel_butterfly_o, sel_red_o
  );
endinterface

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: butterfly pair addresses and twiddle index from pair counter and stride.
module ntt_addr_gen
  import ntt_pkg::*;
(
  input  logic [ADDR_W-2:0] j,
  input  logic [2:0]        s,
  input  logic              inverse,
  output logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] b,
  output logic [ADDR_W-1:0] tw
);
  logic [ADDR_W-1:0] jj, g, len, base;
  always_comb begin
    jj = {1'b0, j};
    len = ADDR_W'(1) << s;
    g = jj >> s;
    a = (g << ({1'b0, s} + 4'd1)) | (jj & (len - ADDR_W'(1)));
    b = a + len;
    base = ADDR_W'(128) >> s;
    // 256/len wraps to 0 for len=1; modulo-256 arithmetic still yields 255-g.
    tw = inverse ? (base << 1) - ADDR_W'(1) - g : base + g;
  end
endmodule

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: layer/pair sequencer driving one butterfly over a 256-entry polynomial RAM.
module ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int LOG_N = 8
) (
  input logic       clk_i,
  input logic       rst_i,
  ntt_ctrl_if.slave bus
);
  state_t state, state_n;
  logic [LOG_N-2:0] j;
  logic [2:0] s;
  logic inv, red, run, last_layer, wr_en;
  logic [ADDR_W-1:0] a, b, tw, wr_a, wr_b;
  ntt_addr_gen u_addr_gen (.j(j), .s(s), .inverse(inv), .a(a), .b(b), .tw(tw));
  assign run = state == RUN;
  assign last_layer = inv ? s == 3'd7 : s == min_stride(red);
  always_comb begin
    state_n = state == IDLE      ? (bus.start_i ? RUN : IDLE) :
              state == RUN       ? (&j ? LAYER_END : RUN) :
              state == LAYER_END ? (last_layer ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      j <= '0;
      s <= '0;
      inv <= 1'b0;
      red <= 1'b0;
      wr_en <= 1'b0;
      wr_a <= '0;
      wr_b <= '0;
    end else begin
      state <= state_n;
      j <= run ? j + 1'b1 : '0;
      if (state == IDLE && bus.start_i) begin
        inv <= bus.inverse_i;
        red <= bus.sel_red_i;
        s <= bus.inverse_i ? min_stride(bus.sel_red_i) : 3'd7;
      end else if (state == LAYER_END && !last_layer) begin
        s <= inv ? s + 3'd1 : s - 3'd1;
      end
      wr_en <= run;
      wr_a <= bus.rd_addr_a_o;
      wr_b <= bus.rd_addr_b_o;
    end
  end
  assign bus.busy_o = run || state == LAYER_END;
  assign bus.done_o = state == DONE;
  assign bus.rd_en_o = run;
  assign bus.rd_addr_a_o = run ? a : '0;
  assign bus.rd_addr_b_o = run ? b : '0;
  assign bus.tw_addr_o = run ? tw : '0;
  assign bus.wr_en_o = wr_en;
  assign bus.wr_addr_a_o = wr_a;
  assign bus.wr_addr_b_o = wr_b;
  assign bus.sel_butterfly_o = inv;
  assign bus.sel_red_o = red;
endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: directed checks of the NTT sequencer address stream and handshake.
module tb_ntt_ctrl;
  logic clk, rst;
  int n_checks, n_fail;
  logic [7:0] log_a [0:1040];
  logic [7:0] log_b [0:1040];
  logic [7:0] log_tw [0:1040];
  logic log_done [0:1040];
  logic log_rd_en [0:1040];
  logic log_wr_en [0:1040];
  ntt_ctrl_if bus ();
  ntt_ctrl #(.LOG_N(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic logic [45:0] observed();
    return {bus.busy_o, bus.done_o, bus.rd_en_o, bus.rd_addr_a_o, bus.rd_addr_b_o, bus.tw_addr_o,
            bus.wr_en_o, bus.wr_addr_a_o, bus.wr_addr_b_o, bus.sel_butterfly_o, bus.sel_red_o};
  endfunction
  task automatic run_seq(input bit inv, input bit red, input bit disturb, input int rst_at);
    int lay, k, s, len, g, ea, eb, etw, dc, last, nl;
    logic e_run, pen;
    logic [7:0] pa, pb;
    logic [45:0] exp_v, obs_v;
    nl = red ? 7 : 8;
    dc = 129 * nl + 1;
    last = rst_at > 0 ? rst_at + 1 : dc + 2;
    bus.start_i = 1'b1;
    bus.inverse_i = inv;
    bus.sel_red_i = red;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    pen = 1'b0;
    pa = '0;
    pb = '0;
    for (int c = 1; c <= last; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      lay = (c - 1) / 129;
      k = (c - 1) % 129;
      e_run = lay < nl && k < 128;
      ea = 0;
      eb = 0;
      etw = 0;
      if (e_run) begin
        s = inv ? 8 - nl + lay : 7 - lay;
        len = 1 << s;
        g = k / len;
        ea = g * 2 * len + k % len;
        eb = ea + len;
        etw = inv ? 256 / len - 1 - g : 128 / len + g;
      end
      exp_v = {c <= 129 * nl, c == dc, e_run, 8'(ea), 8'(eb), 8'(etw), pen, pa, pb, inv, red};
      if (rst_at > 0 && c == rst_at + 1) exp_v = '0;
      obs_v = observed();
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL seq inv=%0d red=%0d cyc=%0d: got %h exp %h", inv, red, c, obs_v, exp_v);
      end
      if (bus.rd_en_o && bus.wr_en_o) begin
        n_checks++;
        if (bus.rd_addr_a_o == bus.wr_addr_a_o || bus.rd_addr_a_o == bus.wr_addr_b_o ||
            bus.rd_addr_b_o == bus.wr_addr_a_o || bus.rd_addr_b_o == bus.wr_addr_b_o) begin
          n_fail++;
          $display("FAIL overlap cyc=%0d: rd %0d/%0d wr %0d/%0d", c, bus.rd_addr_a_o,
                   bus.rd_addr_b_o, bus.wr_addr_a_o, bus.wr_addr_b_o);
        end
      end
      log_a[c] = bus.rd_addr_a_o;
      log_b[c] = bus.rd_addr_b_o;
      log_tw[c] = bus.tw_addr_o;
      log_done[c] = bus.done_o;
      log_rd_en[c] = bus.rd_en_o;
      log_wr_en[c] = bus.wr_en_o;
      pen = e_run;
      pa = 8'(ea);
      pb = 8'(eb);
      bus.start_i = 1'b0;
      if (disturb && (c == 10 || c == dc)) begin
        bus.start_i = 1'b1;
        bus.inverse_i = ~bus.inverse_i;
        bus.sel_red_i = ~bus.sel_red_i;
      end
      if (rst_at > 0 && c == rst_at) rst = 1'b1;
      if (rst_at > 0 && c == rst_at + 1) rst = 1'b0;
    end
    bus.start_i = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b1;
    bus.inverse_i = 1'b1;
    bus.sel_red_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (observed() !== 46'h0) begin
        n_fail++;
        $display("FAIL reset cyc=%0d: got %h exp 0", i, observed());
      end
    end
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b exp 0", bus.busy_o);
    end
  endtask
  task automatic test_fwd_kyber();
    logic [63:0] got, want;
    run_seq(1'b0, 1'b1, 1'b1, 0);
    got = {log_a[1], log_b[1], log_tw[1], log_a[2], log_b[2], log_a[194], log_b[194], log_tw[194]};
    want = {8'd0, 8'd128, 8'd1, 8'd1, 8'd129, 8'd128, 8'd192, 8'd3};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL fwd_kyber_addr: got %h exp %h", got, want);
    end
    n_checks++;
    if ({log_tw[775], log_tw[902]} !== {8'd64, 8'd127}) begin
      n_fail++;
      $display("FAIL fwd_kyber_last_tw: got %0d..%0d exp 64..127", log_tw[775], log_tw[902]);
    end
    n_checks++;
    if ({log_done[903], log_done[904], log_done[905]} !== 3'b010) begin
      n_fail++;
      $display("FAIL fwd_kyber_done: got %b exp 010", {log_done[903], log_done[904], log_done[905]});
    end
    n_checks++;
    if ({log_rd_en[129], log_wr_en[129], log_rd_en[130], log_wr_en[130]} !== 4'b0110) begin
      n_fail++;
      $display("FAIL layer_end_bubble: got %b exp 0110",
               {log_rd_en[129], log_wr_en[129], log_rd_en[130], log_wr_en[130]});
    end
  endtask
  task automatic test_inv_dilithium();
    logic [47:0] got, want;
    run_seq(1'b1, 1'b0, 1'b0, 0);
    got = {log_a[1], log_b[1], log_tw[1], log_a[2], log_b[2], log_tw[2]};
    want = {8'd0, 8'd1, 8'd255, 8'd2, 8'd3, 8'd254};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL inv_dil_first: got %h exp %h", got, want);
    end
    n_checks++;
    if ({log_tw[904], log_tw[1031], log_a[1031], log_b[1031]} !== {8'd1, 8'd1, 8'd127, 8'd255}) begin
      n_fail++;
      $display("FAIL inv_dil_last: got tw %0d/%0d a %0d b %0d exp 1/1 127 255",
               log_tw[904], log_tw[1031], log_a[1031], log_b[1031]);
    end
    n_checks++;
    if ({log_done[1032], log_done[1033]} !== 2'b01) begin
      n_fail++;
      $display("FAIL inv_dil_done: got %b exp 01", {log_done[1032], log_done[1033]});
    end
  endtask
  task automatic test_reset_mid_run();
    run_seq(1'b0, 1'b0, 1'b0, 500);
    run_seq(1'b0, 1'b0, 1'b0, 0);
    n_checks++;
    if ({log_a[1], log_b[1], log_tw[1], log_done[1033]} !== {8'd0, 8'd128, 8'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL restart_after_reset: got a %0d b %0d tw %0d done %b exp 0 128 1 1",
               log_a[1], log_b[1], log_tw[1], log_done[1033]);
    end
  endtask
  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.start_i = 1'b1;
    bus.inverse_i = 1'b0;
    bus.sel_red_i = 1'b0;
    test_reset();
    test_fwd_kyber();
    test_inv_dilithium();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer that drives one single-cycle `butterfly` instance over a 256-coefficient polynomial RAM to perform a full in-place forward NTT (Cooley-Tukey) or inverse NTT (Gentleman-Sande), for Dilithium or Kyber. It generates all read and write addresses, twiddle ROM addresses and butterfly select lines, and reports completion with a start/busy/done handshake. It is address- and control-only: RAM read data feeds the butterfly directly, and butterfly outputs feed the RAM write ports directly. Final n^-1 scaling of the inverse transform is out of scope.

## Interface
- `LOG_N`, default 8: log2 of the polynomial length; 8 is the only supported value.
- Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  start request; sampled only in IDLE
- `inverse_i`  in  1  0: forward CT, 1: inverse GS; captured on accepted start
- `sel_red_i`  in  1  0: Dilithium, 1: Kyber; captured on accepted start
- `busy_o`  out  1  high in RUN and LAYER_END
- `done_o`  out  1  one-cycle completion pulse
- `rd_en_o`  out  1  RAM read enable, both ports
- `rd_addr_a_o`, `rd_addr_b_o`  out  8  RAM read addresses
- `wr_en_o`  out  1  RAM write enable, both ports
- `wr_addr_a_o`, `wr_addr_b_o`  out  8  RAM write addresses
- `tw_addr_o`  out  8  twiddle ROM address
- `sel_butterfly_o`  out  1  to butterfly: registered `inverse_i`
- `sel_red_o`  out  1  to butterfly: registered `sel_red_i`

## Operation
- FSM states: IDLE, RUN, LAYER_END, DONE.
  - IDLE goes to RUN when `start_i` is high.
  - RUN runs 128 cycles with pair counter j = 0..127, then goes to LAYER_END.
  - LAYER_END goes to RUN (next layer, j = 0), or to DONE after the last layer.
  - DONE goes to IDLE.
- Layer count L: 8 for Dilithium, 7 for Kyber.
- Stride sequence len = 2^s:
  - Forward: s goes from 7 down to 8-L.
  - Inverse: s goes from 8-L up to 7.
- In RUN cycle j:
  - `rd_en_o` = 1.
  - a = ((j >> s) << (s+1)) | (j & (len-1)).
  - b = a + len.
  - group g = j >> s.
- Twiddle index:
  - Forward: `tw_addr_o` = 128/len + g.
  - Inverse: `tw_addr_o` = 256/len − 1 − g.
  - The ROM holds whatever negation inverse mode needs; that is not a controller concern.
- Write side:
  - `wr_en_o`, `wr_addr_a_o` and `wr_addr_b_o` are the read-side signals delayed by exactly one register stage.
  - Writes therefore occur in RUN cycles 1..127 and in LAYER_END.
- LAYER_END is a mandatory bubble: `rd_en_o` = 0, and the last write of the layer drains. The next layer's first read never coincides with the previous layer's last write.
- `sel_butterfly_o` and `sel_red_o` are loaded on an accepted start and held until the next accepted start. Input changes during busy are ignored.
- `start_i` outside IDLE (including in DONE) is ignored.
- Reset mid-operation: the FSM returns to IDLE on the next edge and all outputs go to 0. A pending write is discarded; RAM contents are undefined and a new start is required.

## Timing
- Reset values: every output is 0.
- Start sampled at edge 0: the first RUN cycle is cycle 1.
- Each layer takes 129 cycles (128 RUN + 1 LAYER_END).
- `done_o` is high in cycle 8·129+1 = 1033 for Dilithium and 7·129+1 = 904 for Kyber, then IDLE.
- `busy_o` is high in cycles 1..1032 (Dilithium) or 1..903 (Kyber).
- RAM and twiddle ROM both have 1-cycle synchronous read latency.
- The butterfly is combinational, so data read at issue cycle t is written back at t+1.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.

## Structure
- `ntt_pkg`:
  - FSM state enum.
  - Q_DILITHIUM = 8380417, Q_KYBER = 3329.
  - Layer counts 8 and 7.
  - N = 256 and address width 8.
- Sub-module `ntt_addr_gen`: combinational; from (j, s, inverse) produces a, b and the twiddle index.
- `ntt_ctrl` holds the FSM, the j/s counters and the write-side delay registers.

## Test plan
- Reset: assert `rst_i` for 2 cycles with `start_i` = 1 → all outputs 0, no `busy_o`.
- Forward Kyber, with `start_i` = 1, `inverse_i` = 0, `sel_red_i` = 1:
  - Cycle 1: a = 0, b = 128, tw = 1. Cycle 2: a = 1, b = 129.
  - Layer 2, j = 64: a = 128, b = 192, tw = 3.
  - Last layer: len = 2, tw 64..127.
  - `done_o` in cycle 904.
- Inverse Dilithium:
  - First layer, j = 0: a = 0, b = 1, tw = 255. j = 1: a = 2, b = 3, tw = 254.
  - Last layer: len = 128, tw = 1.
  - `done_o` in cycle 1033.
- Write alignment:
  - `wr_*` equals the previous cycle's `rd_*` in every cycle.
  - In LAYER_END, `rd_en_o` = 0 and `wr_en_o` = 1.
  - No cycle reads and writes the same address.
- Pulse `start_i` and toggle `inverse_i`/`sel_red_i` at cycles 10 and 904 (Kyber run, the DONE cycle) → the run is unaffected, no restart, and the selects stay as captured.
- Reset at cycle 500 → all outputs 0 next cycle. A subsequent start produces the full sequence from cycle 1.
